// File: rtl/multi_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// multi_alarm_ctrl
//   Holds N_ALARMS BCD alarm times (each with its own enable) and compares
//   them against the running clock on every minute tick. A hit starts the
//   buzzer. The buzzer stops on a stop request, when the master enable drops,
//   or after RING_MAX minutes of unattended ringing.
//
//   Optional feature, macro MULTI_ALARM_SNOOZE_EN:
//     adds the SNOOZE input, the SNZ state and the snooze minute counter.
//     When undefined, state_o never reports SNZ.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   c_hour1..c_min0         current time (BCD), valid while min_tick=1
//   min_tick                one-cycle pulse at each new minute
//   wr_en, wr_sel, wr_*     alarm storage write port (wr_sel >= N_ALARMS ignored)
//   wr_on                   per-channel enable, written together with the time
//   AL_ON                   master enable (level)
//   STOP_al                 stop request (level)
//   SNOOZE                  snooze request (level, snooze build only)
//   Alarm                   registered buzzer drive
//   alarm_id                registered index of the channel that rang
//   state_o                 FSM state: 0 IDLE, 1 RING, 2 SNZ
//
// Handshake note: there is no valid/ready traffic here. wr_en is a plain
//   write strobe accepted on every edge it is high; min_tick qualifies the
//   c_* time inputs in the same cycle.
// -----------------------------------------------------------------------------
module multi_alarm_ctrl #(
  parameter int N_ALARMS   = 4,
  parameter int RING_MAX   = 5,
  parameter int SNOOZE_MIN = 9,
  localparam int IDXW      = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      c_hour1,
  input  logic [3:0]      c_hour0,
  input  logic [3:0]      c_min1,
  input  logic [3:0]      c_min0,
  input  logic            min_tick,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_sel,
  input  logic [1:0]      wr_hour1,
  input  logic [3:0]      wr_hour0,
  input  logic [3:0]      wr_min1,
  input  logic [3:0]      wr_min0,
  input  logic            wr_on,
  input  logic            AL_ON,
  input  logic            STOP_al,
`ifdef MULTI_ALARM_SNOOZE_EN
  input  logic            SNOOZE,
`endif
  output logic            Alarm,
  output logic [IDXW-1:0] alarm_id,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RING = 2'd1,
    S_SNZ  = 2'd2
  } state_t;

  localparam logic [IDXW:0] N_LIM      = (IDXW + 1)'(N_ALARMS);
  localparam logic [5:0]    RING_MAX_C = 6'(RING_MAX);

  state_t      state;
  logic [5:0]  ring_cnt;
  logic [5:0]  ring_inc;
`ifdef MULTI_ALARM_SNOOZE_EN
  localparam logic [5:0] SNOOZE_C = 6'(SNOOZE_MIN);
  logic [5:0]  snz_cnt;
  logic [5:0]  snz_dec;
`endif

  // Stored alarm time packed as {hour1, hour0, min1, min0}.
  logic [13:0] al_time [N_ALARMS];
  logic        al_on   [N_ALARMS];

  logic [13:0]     cur_time;
  logic            any_hit;
  logic [IDXW-1:0] hit_idx;

  assign cur_time = {c_hour1, c_hour0, c_min1, c_min0};
  assign state_o  = state;

  // Counters saturate instead of wrapping.
  assign ring_inc = (ring_cnt == 6'h3F) ? ring_cnt : ring_cnt + 6'd1;
`ifdef MULTI_ALARM_SNOOZE_EN
  assign snz_dec  = (snz_cnt == 6'd0) ? snz_cnt : snz_cnt - 6'd1;
`endif

  // Scanning downward leaves the lowest matching index in hit_idx.
  // Reads the registered storage, so a same-cycle write compares the old value.
  always_comb begin
    any_hit = 1'b0;
    hit_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (al_on[i] && (al_time[i] == cur_time)) begin
        any_hit = 1'b1;
        hit_idx = IDXW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_ALARMS; i++) begin
        al_time[i] <= '0;
        al_on[i]   <= 1'b0;
      end
    end else if (wr_en && ({1'b0, wr_sel} < N_LIM)) begin
      al_time[wr_sel] <= {wr_hour1, wr_hour0, wr_min1, wr_min0};
      al_on[wr_sel]   <= wr_on;
    end
  end

  // Branch order inside each state encodes the cycle priority:
  // master enable, stop, snooze, timeout/expiry, match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      Alarm    <= 1'b0;
      alarm_id <= '0;
      ring_cnt <= '0;
`ifdef MULTI_ALARM_SNOOZE_EN
      snz_cnt  <= '0;
`endif
    end else if (!AL_ON) begin
      state <= S_IDLE;
      Alarm <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (min_tick && any_hit && !STOP_al) begin
            state    <= S_RING;
            Alarm    <= 1'b1;
            alarm_id <= hit_idx;
            ring_cnt <= '0;
          end
        end
        S_RING: begin
          if (STOP_al) begin
            state <= S_IDLE;
            Alarm <= 1'b0;
          end
`ifdef MULTI_ALARM_SNOOZE_EN
          else if (SNOOZE) begin
            state   <= S_SNZ;
            Alarm   <= 1'b0;
            snz_cnt <= SNOOZE_C;
          end
`endif
          else if (min_tick) begin
            ring_cnt <= ring_inc;
            if (ring_inc >= RING_MAX_C) begin
              state <= S_IDLE;
              Alarm <= 1'b0;
            end
          end
        end
`ifdef MULTI_ALARM_SNOOZE_EN
        S_SNZ: begin
          if (STOP_al) begin
            state <= S_IDLE;
            Alarm <= 1'b0;
          end else if (min_tick) begin
            snz_cnt <= snz_dec;
            if (snz_dec == 6'd0) begin
              state    <= S_RING;
              Alarm    <= 1'b1;
              ring_cnt <= '0;
            end
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          Alarm <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multi_alarm_ctrl
//   Directed scenarios followed by a randomized phase, all checked against a
//   behavioural model of the alarm rules (modes, minute counts, per-channel
//   fields). Works with or without MULTI_ALARM_SNOOZE_EN.
// -----------------------------------------------------------------------------
module tb_multi_alarm_ctrl;

  localparam int N_ALARMS   = 4;
  localparam int RING_MAX   = 5;
  localparam int SNOOZE_MIN = 9;
  localparam int IDXW       = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [1:0]      c_hour1 = '0;
  logic [3:0]      c_hour0 = '0, c_min1 = '0, c_min0 = '0;
  logic            min_tick = 1'b0;
  logic            wr_en = 1'b0;
  logic [IDXW-1:0] wr_sel = '0;
  logic [1:0]      wr_hour1 = '0;
  logic [3:0]      wr_hour0 = '0, wr_min1 = '0, wr_min0 = '0;
  logic            wr_on = 1'b0;
  logic            AL_ON = 1'b0;
  logic            STOP_al = 1'b0;
  logic            SNOOZE = 1'b0;
  logic            Alarm;
  logic [IDXW-1:0] alarm_id;
  logic [1:0]      state_o;

  multi_alarm_ctrl #(
    .N_ALARMS(N_ALARMS), .RING_MAX(RING_MAX), .SNOOZE_MIN(SNOOZE_MIN)
  ) dut (
    .clk(clk), .reset(reset),
    .c_hour1(c_hour1), .c_hour0(c_hour0), .c_min1(c_min1), .c_min0(c_min0),
    .min_tick(min_tick),
    .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_hour1(wr_hour1), .wr_hour0(wr_hour0), .wr_min1(wr_min1), .wr_min0(wr_min0),
    .wr_on(wr_on), .AL_ON(AL_ON), .STOP_al(STOP_al),
`ifdef MULTI_ALARM_SNOOZE_EN
    .SNOOZE(SNOOZE),
`endif
    .Alarm(Alarm), .alarm_id(alarm_id), .state_o(state_o)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_mism = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mism++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 quiet, 1 ringing, 2 snoozing
  int m_h1 [N_ALARMS], m_h0 [N_ALARMS], m_m1 [N_ALARMS], m_m0 [N_ALARMS];
  bit m_en [N_ALARMS];
  int m_mode, m_id, m_rung_min, m_snz_left;

  task automatic model_reset();
    for (int i = 0; i < N_ALARMS; i++) begin
      m_h1[i] = 0; m_h0[i] = 0; m_m1[i] = 0; m_m0[i] = 0; m_en[i] = 0;
    end
    m_mode = 0; m_id = 0; m_rung_min = 0; m_snz_left = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int first_hit;
    bit snz_req;
    first_hit = -1;
    for (int i = 0; i < N_ALARMS; i++)
      if (first_hit < 0 && m_en[i] && m_h1[i] == c_hour1 && m_h0[i] == c_hour0 &&
          m_m1[i] == c_min1 && m_m0[i] == c_min0)
        first_hit = i;
`ifdef MULTI_ALARM_SNOOZE_EN
    snz_req = SNOOZE;
`else
    snz_req = 0;
`endif
    if (!AL_ON) m_mode = 0;
    else if (m_mode == 0) begin
      if (min_tick && first_hit >= 0 && !STOP_al) begin
        m_mode = 1; m_id = first_hit; m_rung_min = 0;
      end
    end else if (m_mode == 1) begin
      if (STOP_al) m_mode = 0;
      else if (snz_req) begin m_mode = 2; m_snz_left = SNOOZE_MIN; end
      else if (min_tick) begin
        m_rung_min++;
        if (m_rung_min >= RING_MAX) m_mode = 0;
      end
    end else begin
      if (STOP_al) m_mode = 0;
      else if (min_tick) begin
        m_snz_left--;
        if (m_snz_left == 0) begin m_mode = 1; m_rung_min = 0; end
      end
    end
    if (wr_en && wr_sel < N_ALARMS) begin
      m_h1[wr_sel] = wr_hour1; m_h0[wr_sel] = wr_hour0;
      m_m1[wr_sel] = wr_min1;  m_m0[wr_sel] = wr_min0;
      m_en[wr_sel] = wr_on;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    model_step();
    @(posedge clk); #1;
    check("alarm", Alarm, (m_mode == 1));
    check("alarm_id", alarm_id, m_id);
    check("state", state_o, m_mode);
  endtask

  task automatic wr(input int sel, input int h1, input int h0, input int m1, input int m0, input bit on);
    wr_en = 1; wr_sel = IDXW'(sel);
    wr_hour1 = 2'(h1); wr_hour0 = 4'(h0); wr_min1 = 4'(m1); wr_min0 = 4'(m0); wr_on = on;
    cyc();
    wr_en = 0;
  endtask

  task automatic set_time(input int h1, input int h0, input int m1, input int m0);
    c_hour1 = 2'(h1); c_hour0 = 4'(h0); c_min1 = 4'(m1); c_min0 = 4'(m0);
  endtask

  task automatic tick_at(input int h1, input int h0, input int m1, input int m0);
    set_time(h1, h0, m1, m0);
    min_tick = 1;
    cyc();
    min_tick = 0;
  endtask

  task automatic expect_out(input string tag, input bit a, input int id, input int st);
    check({tag, "_alarm"}, Alarm, a);
    check({tag, "_id"}, alarm_id, id);
    check({tag, "_state"}, state_o, st);
  endtask

  task automatic stop_pulse();
    STOP_al = 1; cyc(); STOP_al = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    expect_out("reset", 0, 0, 0);
    cyc();

    // Basic match and stop
    AL_ON = 1;
    wr(2, 1, 2, 3, 4, 1);
    tick_at(1, 2, 3, 4);
    expect_out("match", 1, 2, 1);
    stop_pulse();
    expect_out("stop", 0, 2, 0);

    // Lowest index wins
    wr(0, 0, 7, 0, 0, 1);
    wr(3, 0, 7, 0, 0, 1);
    tick_at(0, 7, 0, 0);
    expect_out("prio_ch0", 1, 0, 1);
    stop_pulse();
    wr(0, 0, 7, 0, 0, 0);
    tick_at(0, 7, 0, 0);
    expect_out("prio_ch3", 1, 3, 1);
    stop_pulse();

    // Gating by AL_ON and STOP_al
    wr(1, 2, 1, 1, 5, 1);
    AL_ON = 0;
    tick_at(2, 1, 1, 5);
    expect_out("gate_alon", 0, 3, 0);
    AL_ON = 1; STOP_al = 1;
    tick_at(2, 1, 1, 5);
    expect_out("gate_stop", 0, 3, 0);
    STOP_al = 0;

    // Auto-off after RING_MAX further ticks
    tick_at(2, 1, 1, 5);
    expect_out("to_start", 1, 1, 1);
    for (int k = 1; k <= RING_MAX; k++) begin
      tick_at(2, 1, 1, 5 + k);
      if (k < RING_MAX) check("to_ringing", Alarm, 1);
    end
    expect_out("timeout", 0, 1, 0);

`ifdef MULTI_ALARM_SNOOZE_EN
    tick_at(2, 1, 1, 5);
    SNOOZE = 1; cyc(); SNOOZE = 0;
    expect_out("snooze", 0, 1, 2);
    for (int k = 0; k < SNOOZE_MIN; k++) begin
      tick_at(2, 2, 0, k);
      if (k < SNOOZE_MIN - 1) check("snz_quiet", Alarm, 0);
    end
    expect_out("snz_expire", 1, 1, 1);
    STOP_al = 1; SNOOZE = 1; cyc(); STOP_al = 0; SNOOZE = 0;
    expect_out("stop_snz", 0, 1, 0);
`endif

    // Same-cycle write compares against the old stored value
    wr(0, 0, 9, 0, 0, 1);
    wr_en = 1; wr_sel = 0; wr_hour1 = 1; wr_hour0 = 0; wr_min1 = 1; wr_min0 = 0; wr_on = 1;
    tick_at(1, 0, 1, 0);
    wr_en = 0;
    expect_out("same_cyc_wr", 0, 1, 0);
    tick_at(1, 0, 1, 0);
    expect_out("new_value", 1, 0, 1);

    // Asynchronous reset mid-ring, checked before any clock edge
    #2 reset = 1;
    #1 check("async_rst_alarm", Alarm, 0);
    check("async_rst_state", state_o, 0);
    model_reset();
    @(posedge clk); #1 reset = 0;
    expect_out("post_rst", 0, 0, 0);
    tick_at(1, 0, 1, 0);
    expect_out("storage_cleared", 0, 0, 0);

    // Randomized phase
    AL_ON = 1;
    for (int n = 0; n < 1500; n++) begin
      wr_en = ($urandom_range(0, 3) == 0);
      wr_sel = IDXW'($urandom_range(0, N_ALARMS - 1));
      wr_hour1 = 2'($urandom_range(0, 1)); wr_hour0 = 4'($urandom_range(0, 2));
      wr_min1 = 4'($urandom_range(0, 1));  wr_min0 = 4'($urandom_range(0, 2));
      wr_on = ($urandom_range(0, 4) != 0);
      set_time($urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 2));
      min_tick = ($urandom_range(0, 2) == 0);
      AL_ON = ($urandom_range(0, 29) != 0);
      STOP_al = ($urandom_range(0, 19) == 0);
      SNOOZE = ($urandom_range(0, 11) == 0);
      cyc();
    end
    wr_en = 0; min_tick = 0; STOP_al = 0; SNOOZE = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
    $finish;
  end

endmodule

// File: doc/multi_alarm_ctrl.md
Name: multi_alarm_ctrl

Overview:
- Parametrised successor to the single-compare alarm block.
- Stores N_ALARMS independent BCD alarm times, each with its own enable, and compares them against the running clock time on every minute tick.
- Sequences the buzzer through ring, optional snooze and auto-timeout states.
- Sits between the time counter (clock digits plus min_tick) and the buzzer/display driver.

Parameters:
- N_ALARMS, 4, number of alarm channels (1..16).
- RING_MAX, 5, minutes of unattended ringing before auto-off (1..63).
- SNOOZE_MIN, 9, snooze duration in minutes (1..63); used only with SNOOZE_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- c_hour1  in  2  current time, tens of hours (BCD).
- c_hour0  in  4  current time, units of hours (BCD).
- c_min1  in  4  current time, tens of minutes (BCD).
- c_min0  in  4  current time, units of minutes (BCD).
- min_tick  in  1  one-cycle pulse; c_* already hold the new minute in this cycle.
- wr_en  in  1  write strobe for alarm storage.
- wr_sel  in  IDXW  channel index to write; IDXW = max(1, clog2(N_ALARMS)).
- wr_hour1  in  2  alarm tens of hours, written on wr_en.
- wr_hour0  in  4  alarm units of hours, written on wr_en.
- wr_min1  in  4  alarm tens of minutes, written on wr_en.
- wr_min0  in  4  alarm units of minutes, written on wr_en.
- wr_on  in  1  per-channel enable, written on wr_en.
- AL_ON  in  1  global alarm master enable (level).
- STOP_al  in  1  stop request (level, sampled every cycle).
- SNOOZE  in  1  snooze request (level); present only with SNOOZE_EN.
- Alarm  out  1  buzzer drive, registered.
- alarm_id  out  IDXW  index of the channel that caused the current or last ring, registered.
- state_o  out  2  FSM state for display: 0 IDLE, 1 RING, 2 SNZ.

Behaviour:
- Reset (async, active-high):
  - All stored times cleared to 00:00, all per-channel enables 0.
  - FSM forced to IDLE; Alarm=0, alarm_id=0, state_o=0; ring and snooze counters cleared.
  - Reset asserted mid-ring drops Alarm immediately (asynchronous).
- Storage:
  - On a clk edge with wr_en=1 and wr_sel<N_ALARMS, the addressed channel loads wr_* and wr_on.
  - wr_sel>=N_ALARMS: write ignored.
  - No BCD validation; values are stored as written.
- Match:
  - hit[i] = on[i] and stored time[i] == {c_hour1,c_hour0,c_min1,c_min0}.
  - Evaluated only in cycles where min_tick=1.
  - A write to channel i in the same cycle as min_tick compares against the old stored value.
  - Multiple hits: lowest index wins and is loaded into alarm_id.
- FSM, all transitions registered:
  - IDLE -> RING when min_tick, any hit, AL_ON=1 and STOP_al=0. Alarm=1 from the next edge (latency 1 cycle after min_tick). ring_cnt cleared to 0.
  - RING -> IDLE when STOP_al=1 (Alarm=0 next edge).
  - RING: ring_cnt increments on each min_tick; when ring_cnt reaches RING_MAX on a min_tick, RING -> IDLE (auto-off).
  - RING -> SNZ on SNOOZE=1 (SNOOZE_EN only). Alarm=0; snz_cnt loaded with SNOOZE_MIN.
  - SNZ: snz_cnt decrements on min_tick; when it reaches 0 on a min_tick, SNZ -> RING with ring_cnt cleared and alarm_id unchanged.
  - SNZ -> IDLE when STOP_al=1.
  - Any state -> IDLE when AL_ON=0, taking effect at the next edge.
  - New hits while in RING or SNZ are ignored; alarm_id is not updated.
- Priority within a cycle:
  - reset > AL_ON=0 > STOP_al > SNOOZE > timeout/snooze expiry > match.
  - STOP_al and SNOOZE together: STOP wins, FSM goes to IDLE.
- Re-trigger:
  - Triggering happens only on min_tick, so a stopped alarm does not re-ring within the same minute.
  - It re-rings the next day, when the clock time matches again.
- Counters are 6 bits wide and saturate; they never wrap.

Optional Feature:
- Macro: MULTI_ALARM_SNOOZE_EN.
- Defined:
  - SNOOZE port exists; SNZ state and snz_cnt are present as described.
- Undefined:
  - No SNOOZE port and no SNZ state; state_o never equals 2.
  - RING exits only via STOP_al, AL_ON=0, timeout or reset.

Test Plan:
- Reset and match: reset, then write ch2 = 12:34 with on=1; AL_ON=1; drive 12:34 with min_tick -> Alarm=1 one cycle later, alarm_id=2. STOP_al=1 -> Alarm=0 next edge.
- Priority: ch0 and ch3 both set to 07:00 with on=1; tick at 07:00 -> alarm_id=0. Repeat with ch0 on=0 -> alarm_id=3.
- Gating: ch1 = 21:15 with on=1, AL_ON=0; tick at 21:15 -> Alarm stays 0. Repeat with AL_ON=1 and STOP_al held high -> Alarm stays 0.
- Timeout: RING_MAX=5; trigger, then issue 5 further min_ticks -> Alarm drops on the 5th tick, state_o=0.
- Snooze (MULTI_ALARM_SNOOZE_EN, SNOOZE_MIN=9): trigger, pulse SNOOZE -> state_o=2 and Alarm=0. After 9 min_ticks -> Alarm=1 with the original alarm_id. STOP_al and SNOOZE in the same cycle -> IDLE.
- Same-cycle write and async reset: write ch0 = 10:10 in the tick cycle at 10:10 when ch0 previously held 09:00 -> no ring. Assert reset mid-RING -> Alarm=0 without waiting for a clock edge.
